// File: rtl/mac_tx_pkg.sv
// mac_tx_pkg: shared types and constants for the mac_tx_framer block.
// Build macro MAC_TX_FRAMER_PAD_EN enables zero-padding of short frames to MIN_FRAME_LEN.
package mac_tx_pkg;

    localparam int MIN_FRAME_LEN = 60;
    localparam int DEF_MAX_LEN   = 1514;
    localparam int DEF_IFG       = 12;

    // The frame buffer is 2048 bytes; counts need one extra bit to hold 2048 itself.
    localparam int RAM_ADDR_W    = 11;
    localparam int CNT_W         = 12;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DISCARD,
        SEND,
        PAD,
        GAP
    } state_e;

endpackage

// File: rtl/mac_tx_framer_ram.sv
// mac_tx_framer_ram: simple dual-port 2048x8 frame buffer, one write port and a
// registered read port, shaped so synthesis maps it onto block RAM.
module mac_tx_framer_ram
    import mac_tx_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // NOTE: neither the array nor its read register has a reset; a reset here would stop block-RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mac_tx_framer.sv
// mac_tx_framer: store-and-forward framer that buffers one AXI-Stream frame and replays it
// to the MAC as a gap-free burst. Define MAC_TX_FRAMER_PAD_EN to zero-pad frames to 60 bytes.
module mac_tx_framer
    import mac_tx_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int IFG     = DEF_IFG
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [7:0]  mac_tx_data,
    output logic        mac_tx_valid,
    output logic        mac_tx_sof,
    output logic        mac_tx_eof,
    output logic [31:0] frame_cnt,
    output logic [31:0] drop_cnt
);

    localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] IFG_C     = CNT_W'(IFG);
`ifdef MAC_TX_FRAMER_PAD_EN
    localparam logic [CNT_W-1:0] MIN_LEN_C = CNT_W'(MIN_FRAME_LEN);
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [31:0]      frame_cnt_q, frame_cnt_d;
    logic [31:0]      drop_cnt_q, drop_cnt_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             zero_q, zero_d;
    logic             wr_en;
    logic             accept;
    logic             to_gap;
    logic [CNT_W-1:0] wr_next;
    logic [7:0]       rd_data;

    assign accept  = s_axis_tvalid && ready_q;
    assign wr_next = wr_cnt_q + CNT_W'(1);

    mac_tx_framer_ram u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_cnt_q[RAM_ADDR_W-1:0]),
        .wr_data_i (s_axis_tdata),
        .rd_addr_i (rd_cnt_q[RAM_ADDR_W-1:0]),
        .rd_data_o (rd_data)
    );

    // NOTE: every always_comb output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        len_d       = len_q;
        rd_cnt_d    = rd_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        valid_d     = 1'b0;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        zero_d      = 1'b0;
        wr_en       = 1'b0;
        to_gap      = 1'b0;

        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    if (wr_next > MAX_LEN_C) begin
                        // An oversize byte that is also the last one ends the frame here.
                        if (s_axis_tlast) begin
                            drop_cnt_d = drop_cnt_q + 32'd1;
                            wr_cnt_d   = '0;
                            state_d    = IDLE;
                        end else begin
                            state_d = DISCARD;
                        end
                    end else begin
                        wr_en    = 1'b1;
                        wr_cnt_d = wr_next;
                        state_d  = LOAD;
                        if (s_axis_tlast) begin
                            len_d    = wr_next;
                            wr_cnt_d = '0;
                            rd_cnt_d = '0;
                            state_d  = SEND;
                        end
                    end
                end
            end
            DISCARD: begin
                if (accept && s_axis_tlast) begin
                    drop_cnt_d = drop_cnt_q + 32'd1;
                    wr_cnt_d   = '0;
                    state_d    = IDLE;
                end
            end
            SEND: begin
                valid_d  = 1'b1;
                sof_d    = (rd_cnt_q == '0);
                rd_cnt_d = rd_cnt_q + CNT_W'(1);
                if (rd_cnt_q == len_q - CNT_W'(1)) begin
`ifdef MAC_TX_FRAMER_PAD_EN
                    if (len_q < MIN_LEN_C) begin
                        state_d = PAD;
                    end else begin
                        eof_d  = 1'b1;
                        to_gap = 1'b1;
                    end
`else
                    eof_d  = 1'b1;
                    to_gap = 1'b1;
`endif
                end
            end
`ifdef MAC_TX_FRAMER_PAD_EN
            PAD: begin
                valid_d  = 1'b1;
                zero_d   = 1'b1;
                rd_cnt_d = rd_cnt_q + CNT_W'(1);
                if (rd_cnt_q == MIN_LEN_C - CNT_W'(1)) begin
                    eof_d  = 1'b1;
                    to_gap = 1'b1;
                end
            end
`endif
            GAP: begin
                // The final byte is still on the wire during the first GAP cycle, hence IFG+1 cycles here.
                gap_cnt_d = gap_cnt_q + CNT_W'(1);
                if (gap_cnt_q == IFG_C) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (to_gap) begin
            state_d     = GAP;
            gap_cnt_d   = '0;
            frame_cnt_d = frame_cnt_q + 32'd1;
        end
    end

    assign ready_d = (state_d == IDLE) || (state_d == LOAD) || (state_d == DISCARD);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            wr_cnt_q    <= '0;
            len_q       <= '0;
            rd_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            len_q       <= len_d;
            rd_cnt_q    <= rd_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            zero_q      <= zero_d;
        end
    end

    // The RAM read register is the data output stage; it is masked so idle and pad bytes read as zero.
    assign mac_tx_data   = (valid_q && !zero_q) ? rd_data : 8'h00;
    assign mac_tx_valid  = valid_q;
    assign mac_tx_sof    = sof_q;
    assign mac_tx_eof    = eof_q;
    assign s_axis_tready = ready_q;
    assign frame_cnt     = frame_cnt_q;
    assign drop_cnt      = drop_cnt_q;

endmodule
